// File: rtl/edge_pulse_detector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_pulse_detector_pkg                                      |
// | Description : Shared types, constants and output equations for the         |
// |               rising-edge / isolated-pulse detector.                       |
// |               HIST_RST       - value the history bits take during reset    |
// |               chan_hist_t    - per-channel history (d1 = a one cycle ago,  |
// |                                d2 = a two cycles ago)                      |
// |               f_posedge      - rising edge seen this cycle                 |
// |               f_pulse        - 0-1-0 pattern ends this cycle               |
// |               f_negedge      - falling edge seen this cycle                |
// | Optional    : EDGE_PULSE_DET_NEGEDGE_EN (f_negedge is always available,    |
// |               only used when the macro is defined)                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package edge_pulse_detector_pkg;

   localparam logic HIST_RST = 1'b0;

   typedef struct packed {
      logic d1;
      logic d2;
   } chan_hist_t;

   localparam chan_hist_t HIST_RST_STATE = '{d1: HIST_RST, d2: HIST_RST};

   function automatic logic f_posedge(input logic a, input chan_hist_t h);
      return a & ~h.d1;
   endfunction

   // Only the 0-1-0 shape counts: a level held for two or more cycles
   // has d2=1 when it drops and is therefore not an isolated pulse.
   function automatic logic f_pulse(input logic a, input chan_hist_t h);
      return ~a & h.d1 & ~h.d2;
   endfunction

   function automatic logic f_negedge(input logic a, input chan_hist_t h);
      return ~a & h.d1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pulse_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_pulse_channel                                           |
// | Description : Single-bit slice of the edge/pulse detector. Holds two       |
// |               cycles of input history and produces Mealy outputs that      |
// |               are valid in the same cycle as the input.                    |
// | Ports       : clk        - rising-edge clock                               |
// |               rst_n      - asynchronous active-low reset                   |
// |               a_i        - sampled input bit                               |
// |               posedge_o  - a_i=1 and it was 0 last cycle                   |
// |               pulse_o    - a_i=0, 1 last cycle, 0 the cycle before         |
// |               negedge_o  - a_i=0 and it was 1 last cycle                   |
// |                            (only with EDGE_PULSE_DET_NEGEDGE_EN)           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module edge_pulse_channel
   import edge_pulse_detector_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic a_i,
   output logic posedge_o,
   output logic pulse_o
`ifdef EDGE_PULSE_DET_NEGEDGE_EN
   ,
   output logic negedge_o
`endif
);

   chan_hist_t hist_q;
   chan_hist_t hist_d;

   // History shifts by one each clock: newest sample into d1, d1 into d2.
   always_comb begin
      hist_d    = hist_q;
      hist_d.d1 = a_i;
      hist_d.d2 = hist_q.d1;
   end

   // Reset clears history immediately so the next high input after
   // reset is reported as a fresh rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= HIST_RST_STATE;
      end else begin
         hist_q <= hist_d;
      end
   end

   // Outputs are combinational from the live input; they also follow
   // the equations during reset, using the cleared history.
   assign posedge_o = f_posedge(a_i, hist_q);
   assign pulse_o   = f_pulse(a_i, hist_q);

`ifdef EDGE_PULSE_DET_NEGEDGE_EN
   assign negedge_o = f_negedge(a_i, hist_q);
`endif

endmodule
`default_nettype wire

// File: rtl/edge_pulse_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_pulse_detector                                          |
// | Description : WIDTH independent channels, each flagging rising edges and   |
// |               isolated one-cycle high pulses on its input bit. Outputs     |
// |               are Mealy (zero latency); history advances on clk.           |
// | Parameters  : WIDTH            - number of channels (default 1)            |
// | Ports       : clk              - rising-edge clock                         |
// |               rst_n            - asynchronous active-low reset             |
// |               a                - input stream, one bit per channel         |
// |               posedge_detected - rising edge per channel                   |
// |               pulse_detected   - 0-1-0 pattern completed per channel       |
// |               negedge_detected - falling edge per channel                  |
// |                                  (only with EDGE_PULSE_DET_NEGEDGE_EN)     |
// | Optional    : EDGE_PULSE_DET_NEGEDGE_EN adds the negedge_detected port     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module edge_pulse_detector
   import edge_pulse_detector_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] posedge_detected,
   output logic [WIDTH-1:0] pulse_detected
`ifdef EDGE_PULSE_DET_NEGEDGE_EN
   ,
   output logic [WIDTH-1:0] negedge_detected
`endif
);

   // Channels share nothing but clock and reset.
   for (genvar k = 0; k < WIDTH; k++) begin : g_chan
      edge_pulse_channel u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .a_i       (a[k]),
         .posedge_o (posedge_detected[k]),
         .pulse_o   (pulse_detected[k])
`ifdef EDGE_PULSE_DET_NEGEDGE_EN
         ,
         .negedge_o (negedge_detected[k])
`endif
      );
   end : g_chan

endmodule
`default_nettype wire

// File: tb/tb_edge_pulse_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_edge_pulse_detector                                       |
// | Description : Self-checking bench for edge_pulse_detector (WIDTH=4).       |
// |               Directed scenarios with literal expectations plus random     |
// |               traffic with mid-cycle resets, compared against a model      |
// |               that keeps the last two input samples and matches the        |
// |               0-1 / 0-1-0 / 1-0 patterns on them.                          |
// | Optional    : EDGE_PULSE_DET_NEGEDGE_EN enables the negedge checks         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_edge_pulse_detector;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] pos;
   logic [W-1:0] pul;
`ifdef EDGE_PULSE_DET_NEGEDGE_EN
   logic [W-1:0] neg;
`endif

   int checks = 0;
   int errors = 0;

   edge_pulse_detector #(.WIDTH(W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .a                (a),
      .posedge_detected (pos),
      .pulse_detected   (pul)
`ifdef EDGE_PULSE_DET_NEGEDGE_EN
      ,
      .negedge_detected (neg)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: most recent samples first ----------
   logic [W-1:0] past[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         past.delete();
      end else begin
         past.push_front(a);
         if (past.size() > 2) void'(past.pop_back());
      end
   end

   function automatic logic [W-1:0] prev(input int n);
      if (past.size() >= n) return past[n-1];
      return '0;
   endfunction

   function automatic logic [W-1:0] m_pos(input logic [W-1:0] cur);
      logic [W-1:0] p1 = prev(1);
      logic [W-1:0] r;
      for (int k = 0; k < W; k++) r[k] = ({p1[k], cur[k]} == 2'b01);
      return r;
   endfunction

   function automatic logic [W-1:0] m_pul(input logic [W-1:0] cur);
      logic [W-1:0] p1 = prev(1);
      logic [W-1:0] p2 = prev(2);
      logic [W-1:0] r;
      for (int k = 0; k < W; k++) r[k] = ({p2[k], p1[k], cur[k]} == 3'b010);
      return r;
   endfunction

   function automatic logic [W-1:0] m_neg(input logic [W-1:0] cur);
      logic [W-1:0] p1 = prev(1);
      logic [W-1:0] r;
      for (int k = 0; k < W; k++) r[k] = ({p1[k], cur[k]} == 2'b10);
      return r;
   endfunction

   // ---------------- stimulus helpers (no checking inside) ----------------
   // Drive a new value just after an edge and return mid-cycle.
   task automatic cyc_drive(input logic [W-1:0] v);
      @(posedge clk);
      #1 a = v;
      #4;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      a     = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- scenarios ---------------------------------------------
   task automatic test_reset();
      #2;
      checks++;
      if (pos !== 4'b0000 || pul !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle pos=%b pul=%b expected 0000/0000", pos, pul);
      end
      a = 4'b0101;
      #1;
      checks++;
      if (pos !== 4'b0101 || pul !== 4'b0000) begin
         errors++;
         $display("FAIL reset_eqn pos=%b pul=%b expected 0101/0000", pos, pul);
      end
      @(posedge clk);
      #2;
      // Clock edge under reset must not load history.
      checks++;
      if (pos !== 4'b0101) begin
         errors++;
         $display("FAIL reset_hold pos=%b expected 0101", pos);
      end
   endtask

   task automatic test_sequence();
      logic [15:0] s_a   = 16'b1001011011110001;
      logic [15:0] s_pos = 16'b1001010010000001;
      logic [15:0] s_pul = 16'b0100100000000000;
      logic [W-1:0] v;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         v = W'($urandom);
         v[0] = s_a[15-i];
         cyc_drive(v);
         checks++;
         if (pos[0] !== s_pos[15-i] || pul[0] !== s_pul[15-i]) begin
            errors++;
            $display("FAIL seq_ch0 cyc=%0d pos=%b pul=%b expected %b/%b",
                     i, pos[0], pul[0], s_pos[15-i], s_pul[15-i]);
         end
         checks++;
         if (pos !== m_pos(a) || pul !== m_pul(a)) begin
            errors++;
            $display("FAIL seq_model cyc=%0d pos=%b pul=%b expected %b/%b",
                     i, pos, pul, m_pos(a), m_pul(a));
         end
      end
   endtask

   task automatic test_level_hold();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc_drive(4'b0001);
         checks++;
         if (pos[0] !== (i == 0) || pul[0] !== 1'b0) begin
            errors++;
            $display("FAIL level_hold cyc=%0d pos=%b pul=%b expected %b/0",
                     i, pos[0], pul[0], (i == 0));
         end
      end
      cyc_drive(4'b0000);
      checks++;
      if (pul[0] !== 1'b0) begin
         errors++;
         $display("FAIL level_fall pul=%b expected 0", pul[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] s_a   = 5'b01010;
      logic [4:0] s_pos = 5'b01010;
      logic [4:0] s_pul = 5'b00101;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc_drive({3'b000, s_a[4-i]});
         checks++;
         if (pos[0] !== s_pos[4-i] || pul[0] !== s_pul[4-i]) begin
            errors++;
            $display("FAIL back_to_back cyc=%0d pos=%b pul=%b expected %b/%b",
                     i, pos[0], pul[0], s_pos[4-i], s_pul[4-i]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc_drive(4'hF);
         checks++;
         if (pos !== ((i == 0) ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL arst_pre cyc=%0d pos=%b expected %b",
                     i, pos, ((i == 0) ? 4'hF : 4'h0));
         end
      end
      @(posedge clk);
      #1 a = 4'hF;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pos !== 4'hF) begin
         errors++;
         $display("FAIL arst_clear pos=%b expected 1111", pos);
      end
      #2 rst_n = 1'b1;
      #1;
      checks++;
      if (pos !== 4'hF || pul !== 4'h0) begin
         errors++;
         $display("FAIL arst_release pos=%b pul=%b expected 1111/0000", pos, pul);
      end
      cyc_drive(4'hF);
      checks++;
      if (pos !== 4'h0) begin
         errors++;
         $display("FAIL arst_after pos=%b expected 0000", pos);
      end
   endtask

   task automatic test_width();
      logic [3:0] p0   = 4'b0101;
      logic [3:0] e0p  = 4'b0101;
      logic [3:0] e0u  = 4'b0010;
      logic [W-1:0] v;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         v    = W'($urandom);
         v[0] = p0[3-i];
         v[3] = 1'b1;
         cyc_drive(v);
         checks++;
         if (pos[3] !== (i == 0) || pul[3] !== 1'b0) begin
            errors++;
            $display("FAIL width_ch3 cyc=%0d pos=%b pul=%b expected %b/0",
                     i, pos[3], pul[3], (i == 0));
         end
         checks++;
         if (pos[0] !== e0p[3-i] || pul[0] !== e0u[3-i]) begin
            errors++;
            $display("FAIL width_ch0 cyc=%0d pos=%b pul=%b expected %b/%b",
                     i, pos[0], pul[0], e0p[3-i], e0u[3-i]);
         end
         checks++;
         if (pos !== m_pos(a) || pul !== m_pul(a)) begin
            errors++;
            $display("FAIL width_model cyc=%0d pos=%b pul=%b expected %b/%b",
                     i, pos, pul, m_pos(a), m_pul(a));
         end
      end
   endtask

   task automatic test_negedge();
`ifdef EDGE_PULSE_DET_NEGEDGE_EN
      logic [3:0] s_a   = 4'b1100;
      logic [3:0] s_neg = 4'b0010;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc_drive({3'b000, s_a[3-i]});
         checks++;
         if (neg[0] !== s_neg[3-i]) begin
            errors++;
            $display("FAIL negedge cyc=%0d neg=%b expected %b", i, neg[0], s_neg[3-i]);
         end
      end
`endif
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1 a = W'($urandom);
         if (($urandom % 32) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
            #2;
         end else begin
            #4;
         end
         checks++;
         if (pos !== m_pos(a) || pul !== m_pul(a)) begin
            errors++;
            $display("FAIL random cyc=%0d a=%b pos=%b pul=%b expected %b/%b",
                     i, a, pos, pul, m_pos(a), m_pul(a));
         end
`ifdef EDGE_PULSE_DET_NEGEDGE_EN
         checks++;
         if (neg !== m_neg(a)) begin
            errors++;
            $display("FAIL random_neg cyc=%0d neg=%b expected %b", i, neg, m_neg(a));
         end
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a     = '0;
      test_reset();
      test_sequence();
      test_level_hold();
      test_back_to_back();
      test_async_reset();
      test_width();
      test_negedge();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
